// File: rtl/reorder_buffer.sv
// Dual-issue in-order retirement buffer with tag write-back and branch squash.
// Define ROB_BYPASS_EN to let a write-back retire in the same cycle.
package rob_pkg;
    localparam int ROB_DEPTH = 16;
    localparam int ROB_TAG_W = $clog2(ROB_DEPTH);
    typedef logic [ROB_TAG_W-1:0] tag_t;
    typedef enum logic [1:0] {EX_NORMAL, EX_EXCEPT, EX_REPLAY} ex_mode_e;
    typedef struct packed {
        logic        is_valid;
        ex_mode_e    mode;
        tag_t        tag;
        logic [31:0] result;
        logic [31:0] pc;
        logic        is_branch_established;
    } ex_result_t;
endpackage

module reorder_buffer
    import rob_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [1:0]       alloc_req_i,
    input  logic [4:0]       alloc_rd_i [2],
    output logic             alloc_ready_o,
    output logic [TAG_W-1:0] alloc_tag_o [2],
    input  ex_result_t       results_i [2],
    output logic [1:0]       commit_valid_o,
    output logic [4:0]       commit_rd_o [2],
    output logic [31:0]      commit_value_o [2],
    output logic [TAG_W:0]   count_o
);
    localparam int PW = TAG_W + 1;

    logic [DEPTH-1:0] busy_q, busy_d, done_q, done_d;
    logic [4:0]       rd_q [DEPTH];
    logic [4:0]       rd_d [DEPTH];
    logic [31:0]      val_q [DEPTH];
    logic [31:0]      val_d [DEPTH];
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [1:0]       cv_q, cv_d;
    logic [4:0]       crd_q [2];
    logic [4:0]       crd_d [2];
    logic [31:0]      cval_q [2];
    logic [31:0]      cval_d [2];

    logic [TAG_W-1:0] hidx, tidx, sq_dist, jd;
    logic [TAG_W-1:0] rtag [2];
    logic [TAG_W-1:0] rdist [2];
    logic [TAG_W-1:0] cidx [2];
    logic [31:0]      wval [2];
    logic [31:0]      cval [2];
    logic [1:0]       br, wen, rdy, ret;
    logic             sel, squash;
    logic [PW-1:0]    used;

    assign hidx = head_q[TAG_W-1:0];
    assign tidx = tail_q[TAG_W-1:0];
    assign used = tail_q - head_q;
    assign count_o = used;
    assign squash = |br;
    assign alloc_ready_o = (used <= PW'(DEPTH - 2)) && !squash;
    assign alloc_tag_o[0] = tidx;
    assign alloc_tag_o[1] = alloc_req_i[0] ? tidx + TAG_W'(1) : tidx;
    assign commit_valid_o = cv_q;
    assign commit_rd_o = crd_q;
    assign commit_value_o = cval_q;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rtag[i] = TAG_W'(results_i[i].tag);
            rdist[i] = rtag[i] - hidx;
            br[i] = results_i[i].is_valid
                && results_i[i].is_branch_established
                && busy_q[rtag[i]];
        end
        // Older branch = smaller distance from head.
        sel = br[1] && (!br[0] || rdist[1] < rdist[0]);
        sq_dist = sel ? rdist[1] : rdist[0];
        for (int i = 0; i < 2; i++) begin
            wval[i] = results_i[i].result;
            wen[i] = results_i[i].is_valid && busy_q[rtag[i]]
                && results_i[i].mode == EX_NORMAL;
            if (squash && sel == (i != 0)) begin
                wen[i] = 1'b1;
                wval[i] = results_i[i].pc + 32'd4;
            end
            if (squash && rdist[i] > sq_dist)
                wen[i] = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            cidx[k] = hidx + TAG_W'(k);
            rdy[k] = busy_q[cidx[k]] && done_q[cidx[k]];
            cval[k] = val_q[cidx[k]];
`ifdef ROB_BYPASS_EN
            for (int i = 0; i < 2; i++) begin
                if (wen[i] && rtag[i] == cidx[k]) begin
                    rdy[k] = busy_q[cidx[k]];
                    cval[k] = wval[i];
                end
            end
`endif
        end
        ret[0] = rdy[0];
        ret[1] = rdy[0] && rdy[1] && !(squash && sq_dist == '0);
    end

    always_comb begin
        busy_d = busy_q;
        done_d = done_q;
        rd_d = rd_q;
        val_d = val_q;
        tail_d = tail_q;
        jd = '0;
        head_d = head_q + PW'(ret[0]) + PW'(ret[1]);
        if (alloc_ready_o) begin
            for (int s = 0; s < 2; s++) begin
                if (alloc_req_i[s]) begin
                    busy_d[alloc_tag_o[s]] = 1'b1;
                    done_d[alloc_tag_o[s]] = 1'b0;
                    rd_d[alloc_tag_o[s]] = alloc_rd_i[s];
                end
            end
            tail_d = tail_q + PW'(alloc_req_i[0]) + PW'(alloc_req_i[1]);
        end
        for (int i = 0; i < 2; i++) begin
            if (wen[i]) begin
                done_d[rtag[i]] = 1'b1;
                val_d[rtag[i]] = wval[i];
            end
        end
        if (squash) begin
            for (int j = 0; j < DEPTH; j++) begin
                jd = TAG_W'(j) - hidx;
                if (jd > sq_dist) begin
                    busy_d[j] = 1'b0;
                    done_d[j] = 1'b0;
                end
            end
            tail_d = head_q + PW'(sq_dist) + PW'(1);
        end
        for (int k = 0; k < 2; k++) begin
            if (ret[k]) begin
                busy_d[cidx[k]] = 1'b0;
                done_d[cidx[k]] = 1'b0;
            end
            crd_d[k] = ret[k] ? rd_q[cidx[k]] : '0;
            cval_d[k] = ret[k] ? cval[k] : '0;
        end
        cv_d = ret;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_q <= '0;
            done_q <= '0;
            head_q <= '0;
            tail_q <= '0;
            cv_q <= '0;
            for (int k = 0; k < 2; k++) begin
                crd_q[k] <= '0;
                cval_q[k] <= '0;
            end
            for (int j = 0; j < DEPTH; j++) begin
                rd_q[j] <= '0;
                val_q[j] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            rd_q <= rd_d;
            val_q <= val_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cv_q <= cv_d;
            crd_q <= crd_d;
            cval_q <= cval_d;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer; retire order/values checked by a monitor.
module tb_reorder_buffer;
    import rob_pkg::*;

`ifdef ROB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] v;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  areq;
    logic [4:0]  ard [2];
    logic        ardy;
    logic [3:0]  atag [2];
    ex_result_t  res [2];
    logic [1:0]  cv;
    logic [4:0]  crd [2];
    logic [31:0] cval [2];
    logic [4:0]  cnt;

    exp_t        sb [$];
    exp_t        mon_e;
    logic [31:0] tv [16];
    int          btail;
    int          seq;
    int          n_cmp;
    int          n_bad;

    reorder_buffer dut (
        .clk_i(clk),
        .reset_i(reset),
        .alloc_req_i(areq),
        .alloc_rd_i(ard),
        .alloc_ready_o(ardy),
        .alloc_tag_o(atag),
        .results_i(res),
        .commit_valid_o(cv),
        .commit_rd_o(crd),
        .commit_value_o(cval),
        .count_o(cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        for (int s = 0; s < 2; s++) begin
            if (cv[s]) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL retire%0d: got rd=%0d val=%h, required no retire",
                             s, crd[s], cval[s]);
                end else begin
                    mon_e = sb.pop_front();
                    if (crd[s] !== mon_e.rd || cval[s] !== mon_e.v) begin
                        n_bad++;
                        $display("FAIL retire%0d: got rd=%0d val=%h, required rd=%0d val=%h",
                                 s, crd[s], cval[s], mon_e.rd, mon_e.v);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        areq = '0;
        ard[0] = '0;
        ard[1] = '0;
        res[0] = '0;
        res[1] = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        sb.delete();
        btail = 0;
    endtask

    task automatic alloc(input logic [1:0] req);
        int t;
        for (int s = 0; s < 2; s++) begin
            if (req[s]) begin
                t = btail % 16;
                seq++;
                ard[s] = 5'((seq % 31) + 1);
                tv[t] = 32'hA000_0000 + 32'(seq);
                sb.push_back(exp_t'{ard[s], tv[t]});
                btail++;
            end
        end
        areq = req;
    endtask

    task automatic wb(input int s, input int tag, input logic [31:0] v);
        res[s].is_valid = 1'b1;
        res[s].mode = EX_NORMAL;
        res[s].tag = tag_t'(tag);
        res[s].result = v;
    endtask

    task automatic br(input int s, input int tag, input logic [31:0] pc);
        res[s].is_valid = 1'b1;
        res[s].mode = EX_NORMAL;
        res[s].tag = tag_t'(tag);
        res[s].result = 32'hDEAD_BEEF;
        res[s].pc = pc;
        res[s].is_branch_established = 1'b1;
    endtask

    task automatic squash_model(input int drop, input logic [31:0] v, input int nt);
        exp_t e;
        for (int k = 0; k < drop; k++) e = sb.pop_back();
        e = sb.pop_back();
        e.v = v;
        sb.push_back(e);
        btail = nt;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (cnt != 0 && n < 60) begin
            tick();
            n++;
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        areq = 2'b11;
        ard[0] = 5'd7;
        ard[1] = 5'd8;
        tick();
        n_cmp++;
        if (cnt !== 5'd2) begin
            n_bad++;
            $display("FAIL rst_pre_count: got %0d, required 2", cnt);
        end
        wb(0, 0, 32'h77);
        wb(1, 1, 32'h88);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (cv !== 2'b00 || cnt !== 5'd0) begin
            n_bad++;
            $display("FAIL rst_state: got cv=%b cnt=%0d, required 00/0", cv, cnt);
        end
        n_cmp++;
        if (ardy !== 1'b1 || atag[0] !== 4'd0) begin
            n_bad++;
            $display("FAIL rst_alloc: got rdy=%b tag=%0d, required 1/0", ardy, atag[0]);
        end
        n_cmp++;
        if (crd[0] !== 5'd0 || cval[0] !== 32'd0 || cval[1] !== 32'd0) begin
            n_bad++;
            $display("FAIL rst_commit: got rd=%0d v=%h, required 0/0", crd[0], cval[0]);
        end
        tick();
        n_cmp++;
        if (cv !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_after: got cv=%b, required 00", cv);
        end
    endtask

    task automatic test_basic();
        areq = 2'b11;
        ard[0] = 5'd3;
        ard[1] = 5'd4;
        #1;
        n_cmp++;
        if (atag[0] !== 4'd0 || atag[1] !== 4'd1) begin
            n_bad++;
            $display("FAIL basic_tags: got %0d/%0d, required 0/1", atag[0], atag[1]);
        end
        sb.push_back(exp_t'{5'd3, 32'h11});
        sb.push_back(exp_t'{5'd4, 32'h22});
        btail = 2;
        tick();
        n_cmp++;
        if (cnt !== 5'd2) begin
            n_bad++;
            $display("FAIL basic_count: got %0d, required 2", cnt);
        end
        wb(0, 1, 32'h22);
        tick();
        n_cmp++;
        if (cv !== 2'b00) begin
            n_bad++;
            $display("FAIL basic_young_done: got cv=%b, required 00", cv);
        end
        wb(0, 0, 32'h11);
        tick();
        n_cmp++;
        if (cv !== (BYP ? 2'b11 : 2'b00)) begin
            n_bad++;
            $display("FAIL basic_lat0: got cv=%b, required %b", cv, BYP ? 2'b11 : 2'b00);
        end
        tick();
        n_cmp++;
        if (cv !== (BYP ? 2'b00 : 2'b11) || cnt !== 5'd0) begin
            n_bad++;
            $display("FAIL basic_lat1: got cv=%b cnt=%0d, required %b/0",
                     cv, cnt, BYP ? 2'b00 : 2'b11);
        end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int k = 0; k < 7; k++) begin
            alloc(2'b11);
            tick();
        end
        n_cmp++;
        if (cnt !== 5'd14 || ardy !== 1'b1) begin
            n_bad++;
            $display("FAIL full14: got cnt=%0d rdy=%b, required 14/1", cnt, ardy);
        end
        alloc(2'b01);
        tick();
        n_cmp++;
        if (cnt !== 5'd15 || ardy !== 1'b0) begin
            n_bad++;
            $display("FAIL full15: got cnt=%0d rdy=%b, required 15/0", cnt, ardy);
        end
        areq = 2'b11;
        ard[0] = 5'd9;
        ard[1] = 5'd9;
        tick();
        n_cmp++;
        if (cnt !== 5'd15) begin
            n_bad++;
            $display("FAIL full_drop: got cnt=%0d, required 15", cnt);
        end
        wb(0, 0, tv[0]);
        wb(1, 1, tv[1]);
        tick();
        tick();
        n_cmp++;
        if (cnt !== 5'd13 || ardy !== 1'b1) begin
            n_bad++;
            $display("FAIL full_retire: got cnt=%0d rdy=%b, required 13/1", cnt, ardy);
        end
        alloc(2'b11);
        #1;
        n_cmp++;
        if (atag[0] !== 4'd15 || atag[1] !== 4'd0) begin
            n_bad++;
            $display("FAIL wrap_tags: got %0d/%0d, required 15/0", atag[0], atag[1]);
        end
        tick();
        for (int k = 2; k <= 16; k += 2) begin
            wb(0, k % 16, tv[k % 16]);
            if (k < 16) wb(1, k + 1, tv[k + 1]);
            tick();
        end
        wait_empty();
        n_cmp++;
        if (cnt !== 5'd0 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL wrap_drain: got cnt=%0d left=%0d, required 0/0", cnt, sb.size());
        end
    endtask

    task automatic test_out_of_order();
        logic [1:0] ex [4];
        ex[0] = BYP ? 2'b01 : 2'b00;
        ex[1] = BYP ? 2'b11 : 2'b01;
        ex[2] = BYP ? 2'b01 : 2'b11;
        ex[3] = BYP ? 2'b00 : 2'b01;
        do_reset();
        alloc(2'b11);
        tick();
        alloc(2'b11);
        tick();
        wb(0, 2, tv[2]);
        tick();
        wb(1, 3, tv[3]);
        tick();
        tick();
        n_cmp++;
        if (cv !== 2'b00 || cnt !== 5'd4) begin
            n_bad++;
            $display("FAIL ooo_hold: got cv=%b cnt=%0d, required 00/4", cv, cnt);
        end
        for (int c = 0; c < 4; c++) begin
            if (c == 0) wb(0, 0, tv[0]);
            if (c == 1) wb(1, 1, tv[1]);
            tick();
            n_cmp++;
            if (cv !== ex[c]) begin
                n_bad++;
                $display("FAIL ooo_step%0d: got cv=%b, required %b", c, cv, ex[c]);
            end
        end
        tick();
        n_cmp++;
        if (cnt !== 5'd0) begin
            n_bad++;
            $display("FAIL ooo_count: got %0d, required 0", cnt);
        end
    endtask

    task automatic test_squash();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            alloc(2'b11);
            tick();
        end
        br(0, 2, 32'h100);
        wb(1, 4, 32'h4444);
        #1;
        n_cmp++;
        if (ardy !== 1'b0) begin
            n_bad++;
            $display("FAIL sq_ready: got %b, required 0", ardy);
        end
        tick();
        squash_model(3, 32'h104, 3);
        n_cmp++;
        if (cnt !== 5'd3 || atag[0] !== 4'd3) begin
            n_bad++;
            $display("FAIL sq_tail: got cnt=%0d tag=%0d, required 3/3", cnt, atag[0]);
        end
        alloc(2'b11);
        tick();
        wb(0, 0, tv[0]);
        wb(1, 1, tv[1]);
        tick();
        wb(0, 3, tv[3]);
        for (int k = 0; k < 5; k++) tick();
        n_cmp++;
        if (cnt !== 5'd1) begin
            n_bad++;
            $display("FAIL sq_pending: got cnt=%0d, required 1", cnt);
        end
        wb(1, 4, tv[4]);
        tick();
        wait_empty();
        n_cmp++;
        if (cnt !== 5'd0 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL sq_drain: got cnt=%0d left=%0d, required 0/0", cnt, sb.size());
        end
    endtask

    task automatic test_dual_branch();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            alloc(2'b11);
            tick();
        end
        br(0, 5, 32'h200);
        br(1, 3, 32'h300);
        tick();
        squash_model(2, 32'h304, 4);
        n_cmp++;
        if (cnt !== 5'd4 || atag[0] !== 4'd4) begin
            n_bad++;
            $display("FAIL dual_tail: got cnt=%0d tag=%0d, required 4/4", cnt, atag[0]);
        end
        wb(0, 0, tv[0]);
        wb(1, 1, tv[1]);
        tick();
        wb(0, 2, tv[2]);
        tick();
        wait_empty();
        n_cmp++;
        if (cnt !== 5'd0 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL dual_drain: got cnt=%0d left=%0d, required 0/0", cnt, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 7; k++) begin
            alloc(2'b11);
            tick();
        end
        wb(0, 0, tv[0]);
        wb(1, 1, tv[1]);
        tick();
        alloc(2'b11);
        tick();
        n_cmp++;
        if (cnt !== 5'd14) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d, required 14", cnt);
        end
        for (int k = 2; k < 16; k += 2) begin
            wb(0, k, tv[k]);
            wb(1, k + 1, tv[k + 1]);
            tick();
        end
        wait_empty();
        n_cmp++;
        if (cnt !== 5'd0 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_drain: got cnt=%0d left=%0d, required 0/0", cnt, sb.size());
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        seq = 0;
        btail = 0;
        reset = 1'b1;
        areq = '0;
        ard[0] = '0;
        ard[1] = '0;
        res[0] = '0;
        res[1] = '0;
        test_reset();
        test_basic();
        test_full_wrap();
        test_out_of_order();
        test_squash();
        test_dual_branch();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: run still active, required finish");
        $fatal(1);
    end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement buffer directly downstream of the dual-issue execute stage.
- Allocates up to 2 tagged entries per cycle at dispatch, absorbs both execute results per cycle by tag, and retires up to 2 completed entries per cycle strictly in program order.
- Squashes younger entries when an execute result reports an established branch.

Parameters:
DEPTH, 16, number of entries; power of two, minimum 4
TAG_W, $clog2(DEPTH), entry index width; equals tag_t width

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
alloc_req[2]  input  1 each  dispatch slot i requests an entry; slot 1 is younger than slot 0
alloc_rd[2]  input  5 each  destination register of the allocating instruction; 0 = none
alloc_ready  output  1  at least 2 entries free and no squash this cycle
alloc_tag[2]  output  TAG_W each  tag granted to slot i (combinational from tail)
results[2]  input  ex_result_t each  execute-stage results
commit_valid[2]  output  1 each  registered retire strobe; slot 0 is older
commit_rd[2]  output  5 each  retired destination register
commit_value[2]  output  32 each  retired result value
count  output  TAG_W+1  occupied entries (registered)

Behaviour:
- Storage per entry: busy, done, rd, value.
- Pointers: head and tail are TAG_W+1 bits; the MSB is the wrap bit.
  - count = tail - head.
  - Empty when head == tail; full when count == DEPTH.
- Reset: all busy/done cleared; head = tail = 0; commit_valid = 0; commit_rd = 0; commit_value = 0; count = 0.
- Allocation:
  - Only when alloc_ready.
  - alloc_tag[0] = tail[TAG_W-1:0]; alloc_tag[1] = tail+1 if alloc_req[0], else tail.
  - Allocated entry: busy = 1, done = 0, rd latched. Tail advances by the number of accepted requests.
  - alloc_req while !alloc_ready is dropped; dispatch must hold.
  - alloc_req[1] without alloc_req[0] is legal and takes tail.
- Write-back:
  - A result with is_valid && mode == EX_NORMAL && busy[tag] sets done = 1 and value = result.
  - Results to non-busy entries are ignored. Both slots may write in the same cycle; equal tags are illegal.
- Commit, evaluated from current state each cycle:
  - Slot 0 retires head if busy && done.
  - Slot 1 retires head+1 only if slot 0 retires and head+1 is busy && done.
  - Retired entries are cleared and head advances by 0/1/2.
  - commit_* are registered: 1-cycle latency from the retire decision.
- Squash:
  - A result with is_branch_established = 1 is a squash candidate at its tag T.
  - If both slots establish, the older one (smaller distance from head) wins.
  - All entries strictly younger than T are cleared: busy = 0, done = 0. Tail becomes T+1 with the correct wrap bit.
  - The branch entry itself completes normally with value = pc+4.
  - Write-backs to squashed entries in the same cycle are discarded.
  - alloc_ready = 0 during a squash cycle; allocation resumes next cycle.
  - Commit in the squash cycle proceeds; only older entries can retire.
- Simultaneous commit and allocate when full-minus-2 is legal. alloc_ready uses pre-commit occupancy (conservative).
- Pointer wrap: index bits wrap modulo DEPTH; the wrap bit distinguishes full from empty.
- Reset asserted mid-operation clears everything at the next edge regardless of other inputs; commit_valid = 0 in the following cycle.

Optional Feature:
- Macro: ROB_BYPASS_EN.
- Defined: the commit readiness check also sees this cycle's write-backs. An entry completed by results[i] may retire in the same cycle, using the written value for commit_value.
- Undefined: an entry retires no earlier than the cycle after its write-back. The bypass path is absent.

Test Plan:
- Reset, then allocate 2 (rd 3, rd 4) -> alloc_tag 0/1, count = 2. Write-back tag1 = 0x22, then tag0 = 0x11 -> one cycle later commit_valid = 11, commit_value = {0x11, 0x22}, rd = {3, 4}, count = 0.
- Fill 16 entries -> alloc_ready drops at count 15. Retire 2 -> alloc_ready returns. Pointers wrap: next alloc_tag = 0 after tags 14/15.
- Out-of-order completion: tags 0–3 allocated, write-back tag 2 then tag 3 -> no commit. Write-back tag 0 -> only tag 0 commits. Write-back tag 1 -> tags 1, 2 commit next, then tag 3.
- Squash: tags 0–5 busy; branch at tag 2 established with value 0x104 -> tail = 3, count = 3. Tags 3–5 cleared; a concurrent write-back to tag 4 is ignored; the next alloc_tag is 3.
- Dual branch establish at tags 5 and 3 (head 0) -> tag 3 wins, tail = 4.
- With ROB_BYPASS_EN: write-back to the head tag -> retires the same cycle (commit_valid in the next cycle). Without it -> one cycle later.
